// File: rtl/sa_pkg.sv
// Shared types and defaults for the output-stationary systolic matmul engine.
package sa_pkg;

  typedef enum logic [1:0] {LOAD, FEED, DRAIN} sa_state_t;

  localparam int SA_N_DEF  = 8;
  localparam int SA_DW_DEF = 16;
  localparam int SA_AW_DEF = 32;

  // Cycles needed for the last operand pair to reach PE(N-1,N-1).
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One MAC cell: registered x/w pass-through plus a wrapping signed accumulator.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW = SA_DW_DEF,
  parameter int AW = SA_AW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] w_in,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] w_out,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod_p0;
  logic signed [AW-1:0]   acc_base_p0;
  logic signed [DW-1:0]   x_p1;
  logic signed [DW-1:0]   w_p1;
  logic signed [AW-1:0]   acc_p1;

  function automatic logic signed [AW-1:0] wrap_add(input logic signed [AW-1:0]   a,
                                                    input logic signed [2*DW-1:0] p);
    return a + AW'(p);
  endfunction

  assign prod_p0     = (2*DW)'(x_in) * (2*DW)'(w_in);
  assign acc_base_p0 = clr ? '0 : acc_p1;

  // p0 -> p1: operand forwarding and accumulation
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_p1   <= '0;
      w_p1   <= '0;
      acc_p1 <= '0;
    end else begin
      x_p1 <= x_in;
      w_p1 <= w_in;
      if (en) acc_p1 <= wrap_add(acc_base_p0, prod_p0);
    end
  end

  assign x_out = x_p1;
  assign w_out = w_p1;
  assign acc   = acc_p1;

endmodule

// File: rtl/sa_matmul_engine.sv
// N x N output-stationary systolic matmul: load N k-slices, feed them skewed
// through the PE grid, then stream the N result rows out.
module sa_matmul_engine
  import sa_pkg::*;
#(
  parameter int N  = SA_N_DEF,
  parameter int DW = SA_DW_DEF,
  parameter int AW = SA_AW_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   IN_ACC,
  input  logic [N*DW-1:0]        IN_X,
  input  logic [N*DW-1:0]        IN_W,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [$clog2(N)-1:0]   OUT_ROW,
  output logic [N*AW-1:0]        OUT_DATA,
  output logic                   BUSY
);

  localparam int RW = $clog2(N);
  localparam int FL = feed_len(N);
  localparam int CW = $clog2(FL);
  localparam logic [RW-1:0] K_LAST = RW'(N - 1);
  localparam logic [CW-1:0] F_LAST = CW'(FL - 1);
  localparam logic [CW-1:0] F_SLICES = CW'(N);

  sa_state_t      state, state_nxt;
  logic [RW-1:0]  kcnt;
  logic [RW-1:0]  rcnt;
  logic [CW-1:0]  fcnt;
  logic           acc_keep;
  logic           in_fire;
  logic           out_fire;
  logic           pe_clr;
  logic           pe_en;

  logic signed [DW-1:0] xbuf   [N][N];
  logic signed [DW-1:0] wbuf   [N][N];
  logic signed [DW-1:0] x_head [N];
  logic signed [DW-1:0] w_head [N];
  logic signed [DW-1:0] x_skew [N][N-1];
  logic signed [DW-1:0] w_skew [N][N-1];
  logic signed [DW-1:0] x_edge [N];
  logic signed [DW-1:0] w_edge [N];
  logic signed [DW-1:0] xo     [N][N];
  logic signed [DW-1:0] wo     [N][N];
  logic signed [AW-1:0] acc    [N][N];

  assign IN_READY = (state == LOAD) && !RST;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = OUT_VALID && OUT_READY;
  assign pe_en    = (state == FEED);
  assign pe_clr   = (state == FEED) && (fcnt == '0) && !acc_keep;

  always_comb begin
    state_nxt = state;
    OUT_VALID = 1'b0;
    BUSY      = 1'b1;
    case (state)
      LOAD: begin
        BUSY = 1'b0;
        if (in_fire && kcnt == K_LAST) state_nxt = FEED;
      end
      FEED: begin
        if (fcnt == F_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        OUT_VALID = 1'b1;
        if (out_fire && rcnt == K_LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= LOAD;
      kcnt     <= '0;
      fcnt     <= '0;
      rcnt     <= '0;
      acc_keep <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        kcnt <= (kcnt == K_LAST) ? '0 : kcnt + 1'b1;
        if (kcnt == '0) acc_keep <= IN_ACC;
      end
      if (state == FEED) fcnt <= (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
      if (out_fire) rcnt <= (rcnt == K_LAST) ? '0 : rcnt + 1'b1;
    end
  end

  // Slice buffer holds operand data only; partial tiles are discarded via kcnt.
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      for (int i = 0; i < N; i++) begin
        xbuf[kcnt][i] <= IN_X[i*DW +: DW];
        wbuf[kcnt][i] <= IN_W[i*DW +: DW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_head[i] = '0;
      w_head[i] = '0;
    end
    if (state == FEED && fcnt < F_SLICES) begin
      for (int i = 0; i < N; i++) begin
        x_head[i] = xbuf[fcnt[RW-1:0]][i];
        w_head[i] = wbuf[fcnt[RW-1:0]][i];
      end
    end
  end

  // Skew delay lines: lane i of either edge is delayed i cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N - 1; d++) begin
          x_skew[i][d] <= '0;
          w_skew[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        x_skew[i][0] <= x_head[i];
        w_skew[i][0] <= w_head[i];
        for (int d = 1; d < N - 1; d++) begin
          x_skew[i][d] <= x_skew[i][d-1];
          w_skew[i][d] <= w_skew[i][d-1];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_edge
    if (i == 0) begin : g_direct
      assign x_edge[i] = x_head[i];
      assign w_edge[i] = w_head[i];
    end else begin : g_delayed
      assign x_edge[i] = x_skew[i][i-1];
      assign w_edge[i] = w_skew[i][i-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [DW-1:0] x_in_g;
      logic signed [DW-1:0] w_in_g;
      if (c == 0) begin : g_xl
        assign x_in_g = x_edge[r];
      end else begin : g_xn
        assign x_in_g = xo[r][c-1];
      end
      if (r == 0) begin : g_wt
        assign w_in_g = w_edge[c];
      end else begin : g_wn
        assign w_in_g = wo[r-1][c];
      end
      sa_pe #(.DW(DW), .AW(AW)) u_pe (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (pe_clr),
        .en    (pe_en),
        .x_in  (x_in_g),
        .w_in  (w_in_g),
        .x_out (xo[r][c]),
        .w_out (wo[r][c]),
        .acc   (acc[r][c])
      );
    end
  end

  assign OUT_ROW = rcnt;

  always_comb begin
    OUT_DATA = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < N; j++) OUT_DATA[j*AW +: AW] = acc[rcnt][j];
    end
  end

endmodule

// File: tb/tb_sa_matmul_engine.sv
// Bench for sa_matmul_engine: table of tiles plus reset/backpressure sequences,
// with a queue of expected result rows checked as the engine drains.
module tb_sa_matmul_engine;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int RW = $clog2(N);
  localparam int NV = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic              IN_ACC = 1'b0;
  logic [N*DW-1:0]   IN_X = '0;
  logic [N*DW-1:0]   IN_W = '0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b1;
  logic [RW-1:0]     OUT_ROW;
  logic [N*AW-1:0]   OUT_DATA;
  logic              BUSY;

  sa_matmul_engine #(.N(N), .DW(DW), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_ACC    (IN_ACC),
    .IN_X      (IN_X),
    .IN_W      (IN_W),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_ROW   (OUT_ROW),
    .OUT_DATA  (OUT_DATA),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [RW-1:0]   row;
    logic [N*AW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // mode: 0 = identity X with W[k][j]=k*N+j, 1 = constant X/W, 2 = random
  typedef struct {
    int   mode;
    logic acc;
    int   xv;
    int   wv;
    bit   has_exp;
    int   expv;
    bit   gaps;
    int   stall_row;
    int   stall_len;
  } vec_t;
  vec_t vec [NV];

  logic signed [DW-1:0] xm   [N][N];
  logic signed [DW-1:0] wm   [N][N];
  logic signed [AW-1:0] macc [N][N];

  task automatic check(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no response expected response", name);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      IN_X[i*DW +: DW] = DW'($urandom);
      IN_W[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic fill(input int mode, input int xv, input int wv);
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) begin
        case (mode)
          0: begin
            xm[a][b] = (a == b) ? DW'(1) : DW'(0);
            wm[a][b] = DW'(a * N + b);
          end
          1: begin
            xm[a][b] = DW'(xv);
            wm[a][b] = DW'(wv);
          end
          default: begin
            xm[a][b] = DW'($urandom);
            wm[a][b] = DW'($urandom);
          end
        endcase
      end
    end
  endtask

  // Reference: plain triple-loop matmul with wrap to AW bits.
  task automatic expect_tile(input logic acc, input bit has_exp, input int expv);
    exp_t e;
    logic signed [AW-1:0] s;
    for (int r = 0; r < N; r++) begin
      e.row  = RW'(r);
      e.data = '0;
      for (int j = 0; j < N; j++) begin
        s = acc ? macc[r][j] : '0;
        for (int k = 0; k < N; k++) s = s + AW'(longint'(xm[r][k]) * longint'(wm[k][j]));
        macc[r][j] = s;
        e.data[j*AW +: AW] = has_exp ? AW'(expv) : s;
      end
      sb.push_back(e);
    end
  endtask

  task automatic load_tile(input logic acc, input bit gaps, output int p_last);
    p_last = 0;
    for (int k = 0; k < N; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 1) == 1) begin
        IN_VALID = 1'b0;
        IN_ACC   = ~acc;
        scramble_inputs();
        repeat ($urandom_range(1, 2)) @(negedge CLK);
      end
      IN_VALID = 1'b1;
      IN_ACC   = (k == 0) ? acc : ~acc;
      for (int i = 0; i < N; i++) begin
        IN_X[i*DW +: DW] = xm[i][k];
        IN_W[i*DW +: DW] = wm[k][i];
      end
      check($sformatf("in_ready_beat%0d", k), IN_READY, 1);
      p_last = cyc;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic drain_tile(input int p_last, input int stall_row, input int stall_len, input string tag);
    exp_t            e;
    int              w;
    int              extra;
    logic [N*AW-1:0] hold_d;
    w = 0;
    extra = (stall_row >= 0) ? stall_len : 0;
    while (!OUT_VALID && w < 6 * N) begin
      IN_VALID = (w < 3);
      scramble_inputs();
      @(negedge CLK);
      w++;
    end
    IN_VALID = 1'b0;
    if (!OUT_VALID) begin
      fail_now({tag, "_out_valid_timeout"});
      sb.delete();
      return;
    end
    check({tag, "_latency"}, cyc - p_last, 3 * N - 1);
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) begin
        OUT_READY = 1'b0;
        hold_d = OUT_DATA;
        repeat (stall_len) begin
          @(negedge CLK);
          check({tag, "_stall_valid"}, OUT_VALID, 1);
          check({tag, "_stall_row"}, OUT_ROW, RW'(r));
          check({tag, "_stall_data"}, OUT_DATA, hold_d);
        end
        OUT_READY = 1'b1;
      end
      check($sformatf("%s_valid_r%0d", tag, r), OUT_VALID, 1);
      if (sb.size() == 0) begin
        fail_now({tag, "_scoreboard_empty"});
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_row_r%0d", tag, r), OUT_ROW, e.row);
        check($sformatf("%s_data_r%0d", tag, r), OUT_DATA, e.data);
      end
      @(negedge CLK);
    end
    check({tag, "_done_valid"}, OUT_VALID, 0);
    check({tag, "_done_busy"}, BUSY, 0);
    check({tag, "_done_in_ready"}, IN_READY, 1);
    check({tag, "_ready_latency"}, cyc - p_last, 3 * N - 1 + N + extra);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    vec[0] = '{mode:0, acc:1'b0, xv:0,      wv:0,      has_exp:1'b0, expv:0,  gaps:1'b0, stall_row:-1, stall_len:0};
    vec[1] = '{mode:1, acc:1'b0, xv:1,      wv:1,      has_exp:1'b1, expv:8,  gaps:1'b0, stall_row:-1, stall_len:0};
    vec[2] = '{mode:1, acc:1'b1, xv:1,      wv:1,      has_exp:1'b1, expv:16, gaps:1'b0, stall_row:-1, stall_len:0};
    vec[3] = '{mode:1, acc:1'b0, xv:-32768, wv:-32768, has_exp:1'b1, expv:0,  gaps:1'b0, stall_row:-1, stall_len:0};
    vec[4] = '{mode:1, acc:1'b0, xv:-1,     wv:1,      has_exp:1'b1, expv:-8, gaps:1'b0, stall_row:-1, stall_len:0};
    vec[5] = '{mode:2, acc:1'b0, xv:0,      wv:0,      has_exp:1'b0, expv:0,  gaps:1'b1, stall_row:-1, stall_len:0};
    vec[6] = '{mode:2, acc:1'b1, xv:0,      wv:0,      has_exp:1'b0, expv:0,  gaps:1'b0, stall_row:-1, stall_len:0};
    vec[7] = '{mode:2, acc:1'b0, xv:0,      wv:0,      has_exp:1'b0, expv:0,  gaps:1'b1, stall_row:3,  stall_len:5};
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) macc[a][b] = '0;

    repeat (3) @(negedge CLK);
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_out_row", OUT_ROW, 0);
    check("rst_out_data", OUT_DATA, 0);
    RST = 1'b0;
    #1;
    check("rel_in_ready", IN_READY, 1);
    @(negedge CLK);

    for (int t = 0; t < NV; t++) begin
      fill(vec[t].mode, vec[t].xv, vec[t].wv);
      expect_tile(vec[t].acc, vec[t].has_exp, vec[t].expv);
      load_tile(vec[t].acc, vec[t].gaps, p);
      drain_tile(p, vec[t].stall_row, vec[t].stall_len, $sformatf("v%0d", t));
    end

    // Abort a tile at feed cycle 5; the next accumulate tile must see clean accumulators.
    fill(2, 0, 0);
    load_tile(1'b0, 1'b0, p);
    repeat (5) @(negedge CLK);
    check("midfeed_busy", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_in_ready", IN_READY, 1);
    check("abort_busy", BUSY, 0);
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_out_row", OUT_ROW, 0);
    check("abort_out_data", OUT_DATA, 0);
    @(negedge CLK);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) macc[a][b] = '0;
    fill(2, 0, 0);
    expect_tile(1'b1, 1'b0, 0);
    load_tile(1'b1, 1'b0, p);
    drain_tile(p, -1, 0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_matmul_engine.md
# sa_matmul_engine

Parametrised N×N output-stationary systolic matrix-multiply engine with a load, compute and drain sequence. It accepts N k-slices of operands X and W over a valid/ready input, buffers them, and feeds them with diagonal skew into an internal PE grid. It then streams the N result rows out over a valid/ready output. It supports accumulate-across-tiles mode for K > N tiling. It sits between the controller and the result writeback, replacing the fixed 8×8 enable/write-driven array wrapper.

## Interface
- N, 8, array dimension (rows = cols = k-depth per tile); N ≥ 2
- DW, 16, signed operand width
- AW, 32, signed accumulator/result width; AW ≥ 2·DW
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  input slice valid
- IN_READY  out  1  engine accepts a slice (state LOAD and !RST)
- IN_ACC  in  1  sampled on slice 0 only: 1 = keep accumulators, 0 = clear before compute
- IN_X  in  N·DW  column k of X: lane i = X[i][k]
- IN_W  in  N·DW  row k of W: lane j = W[k][j]
- OUT_VALID  out  1  result row valid
- OUT_READY  in  1  downstream accepts row
- OUT_ROW  out  $clog2(N)  index r of row on OUT_DATA
- OUT_DATA  out  N·AW  lane j = Y[r][j]
- BUSY  out  1  state ≠ LOAD

## Operation
- FSM states: LOAD, FEED, DRAIN. Reset state is LOAD.
- LOAD:
  - Each IN_VALID&IN_READY beat writes slice buffer entry k (k = beat count 0..N-1).
  - On beat 0, latch IN_ACC.
  - On beat N-1, go to FEED.
- FEED:
  - Cycle 0: clear all accumulators unless the latched ACC = 1.
  - Feed cycle c < N: edge presents slice c. Row lane i is delayed i cycles; column lane j is delayed j cycles.
  - Feed cycle c ≥ N: edges present 0.
  - PE(i,j) receives X[i][k] from the left and W[k][j] from above at feed cycle k+i+j. It forwards both one PE right/down per cycle.
  - Each cycle, acc += sext(x·w). The product is signed DW×DW→2DW and is sign-extended to AW. The sum wraps modulo 2^AW, with no saturation.
  - FEED lasts 3N-2 cycles (c = 0..3N-3), then DRAIN.
- DRAIN:
  - OUT_VALID = 1, OUT_ROW = r, OUT_DATA = accumulators of row r.
  - r advances on OUT_VALID&OUT_READY.
  - The handshake on r = N-1 returns to LOAD.
- Accumulators hold through DRAIN and LOAD. This lets the next tile with IN_ACC = 1 add onto them.
- IN_VALID is ignored outside LOAD. OUT_READY is ignored outside DRAIN.

## Timing
- Reset values:
  - IN_READY = 0 while RST is high, 1 in the first cycle after release.
  - OUT_VALID = 0, OUT_ROW = 0, OUT_DATA = 0, BUSY = 0.
  - All counters, skew registers, PE pipelines and accumulators are 0.
- RST in any state, including mid-FEED or mid-DRAIN, aborts the operation. It returns the engine to LOAD with the reset values above on the next edge, and discards partial slices.
- Input: one slice per cycle max. IN_VALID may drop between beats; the count holds.
- Latency: the last input beat is at cycle t. FEED occupies t+1..t+3N-2. First OUT_VALID is at t+3N-1.
- Output: with OUT_READY held at 1, rows appear on N consecutive cycles. IN_READY returns at t+3N-1+N.
- Output stall: OUT_VALID, OUT_ROW and OUT_DATA stay stable while OUT_READY = 0. There is no timeout.
- Minimum tile period: N + (3N-2) + N cycles.

## Structure
- sa_pkg holds:
  - typedef enum logic [1:0] {LOAD, FEED, DRAIN} sa_state_t
  - default parameter constants
  - function feed_len(N) = 3N-2
- Sub-module sa_pe holds one MAC cell:
  - Registered x/w pass-through.
  - Accumulator with clear and enable.
  - Synchronous RST.
- It is instantiated N×N via generate.
- The skew delay lines and slice buffer stay in the top module.

## Test plan
- Identity (N=8): X = I, W[k][j] = k·8+j, IN_ACC = 0 → rows r = 0..7 out on 8 consecutive cycles with Y[r][j] = r·8+j. First OUT_VALID arrives exactly 3N-1 = 23 cycles after the last input beat.
- Accumulate: tile 1 uses all-ones X and W with IN_ACC = 0, tile 2 the same with IN_ACC = 1 → tile 1 gives every Y = 8, tile 2 gives every Y = 16.
- Backpressure: hold OUT_READY = 0 for 5 cycles at row 3, and toggle IN_VALID during LOAD → OUT_ROW stays 3 with data stable, and the result still equals the reference matmul of random signed operands.
- Signed/wrap (DW=16, AW=32): all X = -32768, all W = -32768 with N=8 → each product is 2^30 and the sum of 8 is 2^33, which wraps to Y = 0. Repeat with X = -1, W = 1 → Y = -8.
- Reset mid-FEED: assert RST at feed cycle 5 → next cycle IN_READY = 1, BUSY = 0 and OUT_VALID = 0. A following fresh tile with IN_ACC = 1 yields its product alone, with no stale sums.
- Parameter sweep N=2, 4, DW=8, AW=20 → random tiles match the reference model, with latency 3N-1.
